// File: rtl/csa_operand_sequencer.sv
// ---------------------------------------------------------------------------
// csa_operand_sequencer
//
// Sequential front end for a 16-bit carry-save adder. Collects a stream of
// 16-bit words into triples (A, B, Cin). Each triple is held on the adder
// inputs for SETTLE cycles. The adder's 18-bit result {Cout, SUM} is then
// captured and returned over a result handshake.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid && ready are both 1. The producer holds valid and data
// stable until that edge. ready is decoded from FSM state only and never
// depends on valid.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand word handshake, in_data = word (A, B, Cin order)
//   flush                drops a partially collected triple (LOAD_B/LOAD_C only)
//   csa_a/csa_b/csa_cin  registered operands driven to the adder
//   csa_sum/csa_cout     adder result inputs
//   res_valid/res_ready  result handshake, res_data = {csa_cout, csa_sum}
//   done_cnt             results delivered, wraps modulo 256
//   dbg_state            current FSM state (LOAD_A=0 .. OUT=4)
// ---------------------------------------------------------------------------
module csa_operand_sequencer #(
  parameter int unsigned SETTLE = 1  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        flush,
  output logic [15:0] csa_a,
  output logic [15:0] csa_b,
  output logic [15:0] csa_cin,
  input  logic [16:0] csa_sum,
  input  logic        csa_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [17:0] res_data,
  output logic [7:0]  done_cnt,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    LOAD_C = 3'd2,
    EVAL   = 3'd3,
    OUT    = 3'd4
  } state_e;

  // Count value on which the adder output is sampled.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] cin_q, cin_d;
  logic [17:0] res_q, res_d;
  logic [7:0]  done_q, done_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;

  assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B) ||
                     (state_q == LOAD_C);
  assign res_valid = (state_q == OUT);
  assign accept    = in_valid && in_ready;

  assign csa_a     = a_q;
  assign csa_b     = b_q;
  assign csa_cin   = cin_q;
  assign res_data  = res_q;
  assign done_cnt  = done_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    res_d   = res_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD_A: begin
        if (accept) begin
          a_d     = in_data;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        // flush wins over a simultaneous accept; the word is dropped.
        if (flush) begin
          state_d = LOAD_A;
        end else if (accept) begin
          b_d     = in_data;
          state_d = LOAD_C;
        end
      end
      LOAD_C: begin
        if (flush) begin
          state_d = LOAD_A;
        end else if (accept) begin
          cin_d   = in_data;
          cnt_d   = 4'd0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          res_d   = {csa_cout, csa_sum};
          state_d = OUT;
        end
      end
      OUT: begin
        if (res_ready) begin
          done_d  = done_q + 8'd1;
          state_d = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= '0;
      res_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_csa_operand_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for csa_operand_sequencer. Two instances are built: one with
// SETTLE=1 and one with SETTLE=4. A select bit steers the shared stimulus to
// one of them and picks which outputs are observed. Each instance has its own
// behavioural adder: {cout, sum} = a + b + cin in 18 bits.
// ---------------------------------------------------------------------------
module tb_csa_operand_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        sel;        // 0 -> SETTLE=1 instance, 1 -> SETTLE=4 instance
  logic        in_valid;
  logic [15:0] in_data;
  logic        flush;
  logic        res_ready;

  // ---------------- instance 1 (SETTLE=1) ----------------
  logic        d1_in_valid, d1_flush, d1_res_ready, d1_in_ready, d1_res_valid;
  logic [15:0] d1_a, d1_b, d1_cin;
  logic [16:0] d1_sum;
  logic        d1_cout;
  logic [17:0] d1_res;
  logic [7:0]  d1_done;
  logic [2:0]  d1_state;

  assign d1_in_valid  = in_valid  & ~sel;
  assign d1_flush     = flush     & ~sel;
  assign d1_res_ready = res_ready & ~sel;
  assign {d1_cout, d1_sum} = 18'(d1_a) + 18'(d1_b) + 18'(d1_cin);

  csa_operand_sequencer #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(in_data),
    .flush(d1_flush),
    .csa_a(d1_a), .csa_b(d1_b), .csa_cin(d1_cin),
    .csa_sum(d1_sum), .csa_cout(d1_cout),
    .res_valid(d1_res_valid), .res_ready(d1_res_ready), .res_data(d1_res),
    .done_cnt(d1_done), .dbg_state(d1_state)
  );

  // ---------------- instance 4 (SETTLE=4) ----------------
  logic        d4_in_valid, d4_flush, d4_res_ready, d4_in_ready, d4_res_valid;
  logic [15:0] d4_a, d4_b, d4_cin;
  logic [16:0] d4_sum;
  logic        d4_cout;
  logic [17:0] d4_res;
  logic [7:0]  d4_done;
  logic [2:0]  d4_state;

  assign d4_in_valid  = in_valid  & sel;
  assign d4_flush     = flush     & sel;
  assign d4_res_ready = res_ready & sel;
  assign {d4_cout, d4_sum} = 18'(d4_a) + 18'(d4_b) + 18'(d4_cin);

  csa_operand_sequencer #(.SETTLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_data(in_data),
    .flush(d4_flush),
    .csa_a(d4_a), .csa_b(d4_b), .csa_cin(d4_cin),
    .csa_sum(d4_sum), .csa_cout(d4_cout),
    .res_valid(d4_res_valid), .res_ready(d4_res_ready), .res_data(d4_res),
    .done_cnt(d4_done), .dbg_state(d4_state)
  );

  // ---------------- observed outputs of the selected instance ----------------
  logic        o_in_ready, o_res_valid;
  logic [15:0] o_a, o_b, o_cin;
  logic [17:0] o_res;
  logic [7:0]  o_done;
  logic [2:0]  o_state;

  assign o_in_ready  = sel ? d4_in_ready  : d1_in_ready;
  assign o_res_valid = sel ? d4_res_valid : d1_res_valid;
  assign o_a         = sel ? d4_a         : d1_a;
  assign o_b         = sel ? d4_b         : d1_b;
  assign o_cin       = sel ? d4_cin       : d1_cin;
  assign o_res       = sel ? d4_res       : d1_res;
  assign o_done      = sel ? d4_done      : d1_done;
  assign o_state     = sel ? d4_state     : d1_state;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to 1ns after the next rising edge; drive and sample there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and wait (bounded) for the edge that accepts it.
  // in_valid is left high so words can be streamed back to back.
  task automatic send_word(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 50; i++) begin
      if (o_in_ready) break;
      tick();
    end
    check("in_ready_wait", 32'(o_in_ready), 32'd1);
    tick();
  endtask

  // Wait (bounded) for res_valid and check the captured result.
  task automatic wait_result(input string tag, input logic [17:0] exp);
    for (int i = 0; i < 50; i++) begin
      if (o_res_valid) break;
      tick();
    end
    check({tag, "_valid"}, 32'(o_res_valid), 32'd1);
    check(tag, 32'(o_res), 32'(exp));
  endtask

  // Full triple with res_ready held high; consumes the result.
  task automatic run_triple(input string tag, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] c);
    logic [17:0] exp;
    exp = 18'(a) + 18'(b) + 18'(c);
    send_word(a);
    send_word(b);
    send_word(c);
    in_valid = 1'b0;
    wait_result(tag, exp);
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    sel       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    res_ready = 1'b0;

    // Reset state
    #23;
    check("rst_in_ready",  32'(o_in_ready),  32'd1);
    check("rst_res_valid", 32'(o_res_valid), 32'd0);
    check("rst_res_data",  32'(o_res),       32'd0);
    check("rst_done",      32'(o_done),      32'd0);
    check("rst_csa_a",     32'(o_a),         32'd0);
    check("rst_state",     32'(o_state),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic triple, SETTLE=1: res_valid one cycle after third accept
    res_ready = 1'b1;
    send_word(16'd1);
    send_word(16'd2);
    send_word(16'd3);
    in_valid = 1'b0;
    check("basic_eval_no_valid", 32'(o_res_valid), 32'd0);
    check("basic_eval_in_ready", 32'(o_in_ready),  32'd0);
    tick();
    check("basic_valid", 32'(o_res_valid), 32'd1);
    check("basic_res",   32'(o_res),       32'h00006);
    tick();
    check("basic_done",     32'(o_done),     32'd1);
    check("basic_in_ready", 32'(o_in_ready), 32'd1);

    // Maximum operands, result consumed after a wait
    res_ready = 1'b0;
    send_word(16'hFFFF);
    send_word(16'hFFFF);
    send_word(16'hFFFF);
    in_valid = 1'b0;
    wait_result("max_res", 18'h2FFFD);
    res_ready = 1'b1;
    tick();
    check("max_done", 32'(o_done), 32'd2);
    run_triple("msb_res", 16'h8000, 16'h8000, 16'h0000);
    check("msb_res_exact", 32'(o_res), 32'h10000);
    check("msb_done", 32'(o_done), 32'd3);

    // Backpressure: 5 cycles of res_ready=0 with junk on in_valid
    res_ready = 1'b0;
    send_word(16'd100);
    send_word(16'd200);
    send_word(16'd300);
    in_valid = 1'b0;
    wait_result("bp_res", 18'd600);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid",    32'(o_res_valid), 32'd1);
      check("bp_hold_data",     32'(o_res),       32'd600);
      check("bp_hold_in_ready", 32'(o_in_ready),  32'd0);
      tick();
    end
    in_valid = 1'b0;
    check("bp_csa_a_held", 32'(o_a), 32'd100);
    res_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 32'(o_in_ready), 32'd1);
    check("bp_done",             32'(o_done),     32'd4);
    run_triple("stream_res", 16'd10, 16'd20, 16'd30);
    check("stream_res_exact", 32'(o_res), 32'h0003C);
    check("stream_done", 32'(o_done), 32'd5);

    // Flush in LOAD_C with a simultaneous valid word
    send_word(16'd5);
    send_word(16'd7);
    in_data = 16'd9;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_state",    32'(o_state),    32'd0);
    check("flush_in_ready", 32'(o_in_ready), 32'd1);
    check("flush_csa_a",    32'(o_a),        32'd5);
    check("flush_csa_b",    32'(o_b),        32'd7);
    check("flush_cin_stale", 32'(o_cin),     32'd30);
    // flush is ignored in LOAD_A: the first word still lands
    flush = 1'b1;
    send_word(16'd1);
    flush = 1'b0;
    check("flush_ignored_a", 32'(o_state), 32'd1);
    send_word(16'd1);
    send_word(16'd1);
    in_valid = 1'b0;
    wait_result("flush_res", 18'h00003);
    tick();
    check("flush_done", 32'(o_done), 32'd6);

    // SETTLE=4 instance: latency and operand stability
    sel = 1'b1;
    res_ready = 1'b0;
    tick();
    send_word(16'd2);
    send_word(16'd3);
    send_word(16'd4);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("s4_no_valid", 32'(o_res_valid), 32'd0);
      check("s4_csa_a",    32'(o_a),   32'd2);
      check("s4_csa_b",    32'(o_b),   32'd3);
      check("s4_csa_cin",  32'(o_cin), 32'd4);
      tick();
    end
    check("s4_valid", 32'(o_res_valid), 32'd1);
    check("s4_res",   32'(o_res),       32'd9);
    res_ready = 1'b1;
    tick();
    check("s4_done", 32'(o_done), 32'd1);

    // 255 more triples: done_cnt reaches 255, then wraps to 0
    for (int i = 1; i < 255; i++) begin
      run_triple("wrap_res", 16'(i * 257), ~16'(i * 257), 16'(i));
    end
    check("wrap_done_255", 32'(o_done), 32'd255);
    run_triple("wrap_last_res", 16'hFFFF, 16'h0001, 16'h0002);
    check("wrap_done_0", 32'(o_done), 32'd0);

    // Asynchronous reset in LOAD_C
    sel = 1'b0;
    res_ready = 1'b0;
    tick();
    send_word(16'd5);
    send_word(16'd6);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_c_csa_a",    32'(o_a),         32'd0);
    check("arst_c_csa_b",    32'(o_b),         32'd0);
    check("arst_c_in_ready", 32'(o_in_ready),  32'd1);
    check("arst_c_done",     32'(o_done),      32'd0);
    check("arst_c_res",      32'(o_res),       32'd0);
    rst_n = 1'b1;
    tick();

    // Asynchronous reset during OUT
    send_word(16'd7);
    send_word(16'd8);
    send_word(16'd9);
    in_valid = 1'b0;
    wait_result("arst_o_pre", 18'd24);
    #2 rst_n = 1'b0;
    #1;
    check("arst_o_res_valid", 32'(o_res_valid), 32'd0);
    check("arst_o_res",       32'(o_res),       32'd0);
    check("arst_o_in_ready",  32'(o_in_ready),  32'd1);
    check("arst_o_csa_cin",   32'(o_cin),       32'd0);
    check("arst_o_done",      32'(o_done),      32'd0);
    rst_n = 1'b1;
    tick();
    res_ready = 1'b1;
    run_triple("post_rst_res", 16'd100, 16'd1, 16'd2);
    check("post_rst_exact", 32'(o_res), 32'h00067);
    check("post_rst_done", 32'(o_done), 32'd1);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csa_operand_sequencer.md
# csa_operand_sequencer

Sequential front end for the 16-bit carry-save adder. It accepts a stream of 16-bit words over a valid/ready handshake and groups them into triples. Each triple is held stable on the adder's A, B and Cin inputs for a programmable settle time. The block then captures the adder's full 18-bit result, {Cout, SUM[16:0]}, and returns it over a second valid/ready handshake. It sits directly upstream of the CSA and also collects that adder's output, so the surrounding datapath only ever deals with handshaked words.

## Interface
- SETTLE, 1, cycles the operands are held before the adder output is sampled; legal range 1..15.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  16  operand word. Order within a triple is A, then B, then Cin.
- flush  in  1  synchronous abort of a partially collected triple.
- csa_a / csa_b / csa_cin  out  16 each  operands driven to the adder.
- csa_sum  in  17  adder SUM.
- csa_cout  in  1  adder Cout.
- res_valid  out  1  res_data is valid.
- res_ready  in  1  consumer accepts the result.
- res_data  out  18  {csa_cout, csa_sum} captured at the end of evaluation.
- done_cnt  out  8  number of results delivered; wraps at 255.

## Operation
- FSM states: LOAD_A, LOAD_B, LOAD_C, EVAL, OUT. Reset state is LOAD_A.
- An input word is accepted when in_valid && in_ready.
- in_ready = 1 exactly in LOAD_A, LOAD_B and LOAD_C. It is decoded combinationally from the state, so it reads 1 during reset.
- LOAD_A: on accept, csa_a <= in_data, go to LOAD_B.
- LOAD_B: on accept, csa_b <= in_data, go to LOAD_C.
- LOAD_C: on accept, csa_cin <= in_data, clear the settle counter, go to EVAL.
- EVAL: the settle counter increments each cycle.
  - When the counter equals SETTLE-1: res_data <= {csa_cout, csa_sum}, go to OUT.
- OUT: res_valid = 1. On res_ready: done_cnt increments (255 -> 0) and the FSM goes to LOAD_A.
- The csa_* registers change only on an accept. They hold through EVAL and OUT.
- res_data holds its value until the next capture.
- flush:
  - In LOAD_B or LOAD_C it returns the FSM to LOAD_A and discards the partial triple; csa_* keep their stale values.
  - flush has priority over a simultaneous accept; that word is dropped.
  - flush is ignored in LOAD_A, EVAL and OUT.
- Arithmetic is performed entirely by the CSA. The 18-bit result is never truncated: maximum value 3 × 0xFFFF = 0x2FFFD.
- Reset (asynchronous, at any time, including mid-triple or during OUT):
  - state = LOAD_A;
  - csa_a, csa_b, csa_cin, res_data = 0;
  - res_valid = 0;
  - done_cnt = 0;
  - settle counter = 0.
  - An in-flight result is lost.

## Timing
- Throughput: one word per cycle during loading.
- Latency: third word accepted at edge N, res_valid rises after edge N+SETTLE.
- A result accepted at edge M puts in_ready = 1 in cycle M+1. The next A word can be accepted at edge M+1.
- Minimum cycles per triple is 3 + SETTLE + 1.
- res_valid may stay high indefinitely under backpressure. res_data is stable while res_valid = 1 and res_ready = 0.
- in_ready = 0 throughout EVAL and OUT. in_valid in those states has no effect.
- After rst_n deasserts, the first accept can occur on the first rising edge.

## Test plan
- Basic triple: words 1, 2, 3 with res_ready held 1 and SETTLE=1 -> res_valid one cycle after third accept, res_data = 0x00006, done_cnt = 1.
- Maximum operands: 0xFFFF ×3 -> res_data = 0x2FFFD (Cout = 1, SUM = 0x0FFFD). Then 0x8000, 0x8000, 0x0000 -> 0x10000.
- Backpressure and streaming: res_ready = 0 for 5 cycles -> res_valid and res_data stable, in_ready = 0. Then release -> in_ready = 1 the next cycle. A back-to-back second triple (10, 20, 30) gives 0x0003C.
- Flush: A = 5, B = 7, flush in LOAD_C with in_valid = 1 and data 9 -> word dropped, FSM back in LOAD_A. Triple 1, 1, 1 then gives 0x00003, not 0x00015.
- SETTLE = 4: third accept at edge N -> res_valid first high after edge N+4, and csa_* unchanged throughout EVAL. Run 256 triples -> done_cnt wraps to 0.
- Reset mid-operation: assert rst_n low during LOAD_C and again during OUT -> all outputs zero immediately (asynchronous), in_ready = 1, done_cnt = 0. The next triple computes correctly.
